// File: rtl/servant_uart_loader_if.sv
// Wishbone write-only bus between the UART loader (master) and the RAM port (slave).
interface servant_uart_loader_if;
   logic [31:0] adr;
   logic [31:0] dat;
   logic [3:0]  sel;
   logic        we;
   logic        stb;
   logic        ack;

   modport master (output adr, output dat, output sel, output we, output stb, input ack);
   modport slave  (input adr, input dat, input sel, input we, input stb, output ack);
endinterface

// File: rtl/servant_uart_loader.sv
// Boot-time UART-to-Wishbone program loader.
// Receives an 8N1 image (16-bit word count, then little-endian words) and
// writes it to RAM, holding the CPU in reset until the image is complete.
// Optional feature macro: SERVANT_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte that must match before the CPU is released.
module servant_uart_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int AW           = 13
) (
   input  logic                  wb_clk,
   input  logic                  wb_rst,
   input  logic                  i_rx,
   servant_uart_loader_if.master wb,
   output logic                  o_cpu_rst,
   output logic                  o_done,
   output logic                  o_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [2:0] LD_HDR0  = 3'd0;
   localparam logic [2:0] LD_HDR1  = 3'd1;
   localparam logic [2:0] LD_DATA  = 3'd2;
   localparam logic [2:0] LD_DRAIN = 3'd3;
   localparam logic [2:0] LD_DONE  = 3'd4;
   localparam logic [2:0] LD_ERR   = 3'd5;
`ifdef SERVANT_LOADER_CHECKSUM_EN
   localparam logic [2:0] LD_CSUM  = 3'd6;
`endif

   localparam logic [AW-3:0] IDX_ONE = 1;

   // ---------------------------------------------------------------- RX path
   logic          rx_s1, rx_s2, rx_prev;
   logic [1:0]    rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_byte;
   logic          byte_valid;
   logic          frame_err;

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      // NOTE: every flop uses <= so all registers update together on the edge.
      if (wb_rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= i_rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // 8N1 receiver: mid-bit sampling, single-cycle byte_valid / frame_err pulses.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         rx_state   <= RX_IDLE;
         rx_cnt     <= '0;
         rx_bit     <= 3'd0;
         rx_byte    <= 8'h00;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               if (rx_prev && !rx_s2) rx_state <= RX_START;
            end
            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_bit   <= 3'd0;
                  // Line back high at mid-start means it was only a glitch.
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt  <= '0;
                  rx_byte <= {rx_s2, rx_byte[7:1]};
                  rx_bit  <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            default: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt     <= '0;
                  byte_valid <= rx_s2;
                  frame_err  <= !rx_s2;
                  rx_state   <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
         endcase
      end
   end

   // ------------------------------------------------------------ Loader FSM
   logic [2:0]    ld_state;
   logic [7:0]    hdr_lo;
   logic [15:0]   words_left;
   logic [AW-3:0] idx;
   logic [23:0]   asm_reg;
   logic [1:0]    byte_sel;
   logic [31:0]   adr;
   logic [31:0]   dat;
   logic          stb;
   logic          cpu_rst;
   logic          done;
   logic          err;
   logic          wr_free;
`ifdef SERVANT_LOADER_CHECKSUM_EN
   logic [7:0]    csum;
`endif

   // The bus is free for a new word when idle or when the pending write is acked now.
   assign wr_free = !stb || wb.ack;

   // Header parse, word assembly, Wishbone write issue and completion tracking.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      // NOTE: data registers are reset too so an aborted load leaves no stale word on the bus.
      if (wb_rst) begin
         ld_state   <= LD_HDR0;
         hdr_lo     <= 8'h00;
         words_left <= 16'h0000;
         idx        <= '0;
         asm_reg    <= 24'h000000;
         byte_sel   <= 2'd0;
         adr        <= 32'h0000_0000;
         dat        <= 32'h0000_0000;
         stb        <= 1'b0;
         cpu_rst    <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef SERVANT_LOADER_CHECKSUM_EN
         csum       <= 8'h00;
`endif
      end else begin
         // An acked write ends on this edge unless a new word is issued below.
         if (stb && wb.ack) stb <= 1'b0;

         if (frame_err && ld_state != LD_DONE && ld_state != LD_ERR) begin
            ld_state <= LD_ERR;
            err      <= 1'b1;
         end else begin
            case (ld_state)
               LD_HDR0: begin
                  if (byte_valid) begin
                     hdr_lo   <= rx_byte;
                     ld_state <= LD_HDR1;
                  end
               end
               LD_HDR1: begin
                  if (byte_valid) begin
                     words_left <= {rx_byte, hdr_lo};
                     byte_sel   <= 2'd0;
                     if ({rx_byte, hdr_lo} != 16'h0000) begin
                        ld_state <= LD_DATA;
                     end else begin
`ifdef SERVANT_LOADER_CHECKSUM_EN
                        ld_state <= LD_CSUM;
`else
                        ld_state <= LD_DONE;
                        done     <= 1'b1;
                        cpu_rst  <= 1'b0;
`endif
                     end
                  end
               end
               LD_DATA: begin
                  if (byte_valid) begin
`ifdef SERVANT_LOADER_CHECKSUM_EN
                     csum <= csum ^ rx_byte;
`endif
                     if (byte_sel != 2'd3) begin
                        asm_reg[{byte_sel, 3'b000} +: 8] <= rx_byte;
                        byte_sel <= byte_sel + 2'd1;
                     end else if (!wr_free) begin
                        // Previous word still on the bus: this word is lost.
                        ld_state <= LD_ERR;
                        err      <= 1'b1;
                     end else begin
                        dat        <= {rx_byte, asm_reg};
                        adr        <= {{(32-AW){1'b0}}, idx, 2'b00};
                        stb        <= 1'b1;
                        idx        <= idx + IDX_ONE;
                        byte_sel   <= 2'd0;
                        words_left <= words_left - 16'd1;
                        if (words_left == 16'd1) begin
`ifdef SERVANT_LOADER_CHECKSUM_EN
                           ld_state <= LD_CSUM;
`else
                           ld_state <= LD_DRAIN;
`endif
                        end
                     end
                  end
               end
`ifdef SERVANT_LOADER_CHECKSUM_EN
               LD_CSUM: begin
                  if (byte_valid) begin
                     if (rx_byte == csum) begin
                        ld_state <= LD_DRAIN;
                     end else begin
                        ld_state <= LD_ERR;
                        err      <= 1'b1;
                     end
                  end
               end
`endif
               LD_DRAIN: begin
                  // Release the CPU only once the final write has been acked.
                  if (wr_free) begin
                     ld_state <= LD_DONE;
                     done     <= 1'b1;
                     cpu_rst  <= 1'b0;
                  end
               end
               default: begin
                  ld_state <= ld_state;
               end
            endcase
         end
      end
   end

   // Strobe is gated by reset so an abort drops it without waiting for a clock.
   assign wb.stb    = stb && !wb_rst;
   assign wb.adr    = adr;
   assign wb.dat    = dat;
   assign wb.sel    = 4'hF;
   assign wb.we     = 1'b1;
   assign o_cpu_rst = cpu_rst;
   assign o_done    = done;
   assign o_err     = err;

endmodule

// File: tb/tb_servant_uart_loader.sv
// Self-checking bench for servant_uart_loader: UART byte driver, Wishbone
// responder with programmable ack latency, and a write scoreboard.
// A second instance with AW=4 covers word-index wrap.
module tb_servant_uart_loader;

   localparam int CPB = 16;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;

   always #5 clk = ~clk;

   servant_uart_loader_if bus0 ();
   servant_uart_loader_if bus1 ();

   logic cpu_rst0, done0, err0;
   logic cpu_rst1, done1, err1;

   servant_uart_loader #(.CLKS_PER_BIT(CPB), .AW(13)) u_dut (
      .wb_clk    (clk),
      .wb_rst    (rst),
      .i_rx      (rx),
      .wb        (bus0),
      .o_cpu_rst (cpu_rst0),
      .o_done    (done0),
      .o_err     (err0)
   );

   servant_uart_loader #(.CLKS_PER_BIT(CPB), .AW(4)) u_wrap (
      .wb_clk    (clk),
      .wb_rst    (rst),
      .i_rx      (rx),
      .wb        (bus1),
      .o_cpu_rst (cpu_rst1),
      .o_done    (done1),
      .o_err     (err1)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   wr_t  exp_q0[$];
   wr_t  exp_q1[$];
   wr_t  obs_q0[$];
   wr_t  obs_q1[$];

   logic ack0 = 1'b0;
   logic ack1 = 1'b0;
   int   cnt0 = 0;
   int   cnt1 = 0;
   bit   ack_en0 = 1'b1;
   int   ack_delay = 3;
   int   last_ack_cyc0 = 0;
   int   stb_cnt0 = 0;
   logic stb_prev0 = 1'b0;
   bit   done_seen0 = 1'b0;
   int   done_cyc0 = 0;
   logic [7:0] tx_csum = 8'h00;

   assign bus0.ack = ack0;
   assign bus1.ack = ack1;

   always @(posedge clk) cyc++;

   // Responder for the main instance; also records writes, strobe count and done timing.
   always @(negedge clk) begin
      if (rst) begin
         ack0       = 1'b0;
         cnt0       = 0;
         stb_cnt0   = 0;
         stb_prev0  = 1'b0;
         done_seen0 = 1'b0;
         obs_q0.delete();
      end else begin
         if (bus0.stb && !stb_prev0) stb_cnt0++;
         stb_prev0 = bus0.stb;
         if (done0 && !done_seen0) begin
            done_seen0 = 1'b1;
            done_cyc0  = cyc;
         end
         if (ack0) begin
            ack0 = 1'b0;
            cnt0 = 0;
         end else if (bus0.stb && ack_en0) begin
            if (cnt0 >= ack_delay - 1) begin
               ack0 = 1'b1;
               last_ack_cyc0 = cyc;
               obs_q0.push_back('{adr: bus0.adr, dat: bus0.dat});
            end else begin
               cnt0++;
            end
         end else begin
            cnt0 = 0;
         end
      end
   end

   // Responder for the wrap instance.
   always @(negedge clk) begin
      if (rst) begin
         ack1 = 1'b0;
         cnt1 = 0;
         obs_q1.delete();
      end else if (ack1) begin
         ack1 = 1'b0;
         cnt1 = 0;
      end else if (bus1.stb) begin
         if (cnt1 >= ack_delay - 1) begin
            ack1 = 1'b1;
            obs_q1.push_back('{adr: bus1.adr, dat: bus1.dat});
         end else begin
            cnt1++;
         end
      end else begin
         cnt1 = 0;
      end
   end

   task automatic do_reset();
      rst     = 1'b1;
      rx      = 1'b1;
      ack_en0 = 1'b1;
      tx_csum = 8'h00;
      exp_q0.delete();
      exp_q1.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      logic [7:0] b;
      for (int i = 0; i < 4; i++) begin
         b = w[8*i +: 8];
         tx_csum = tx_csum ^ b;
         send_byte(b, 1'b1);
      end
   endtask

   task automatic send_trailer();
`ifdef SERVANT_LOADER_CHECKSUM_EN
      send_byte(tx_csum, 1'b1);
`endif
   endtask

   task automatic wait_end(input string name, input bit which, input int budget);
      int n;
      n = 0;
      while (n < budget && !(which ? (done1 || err1) : (done0 || err0))) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_timeout: no done/err within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      int n;
      do_reset();
      checks++; if (bus0.adr !== 32'h0)  begin errors++; $display("FAIL reset_adr: got %h expected 0", bus0.adr); end
      checks++; if (bus0.dat !== 32'h0)  begin errors++; $display("FAIL reset_dat: got %h expected 0", bus0.dat); end
      checks++; if (bus0.stb !== 1'b0)   begin errors++; $display("FAIL reset_stb: got %b expected 0", bus0.stb); end
      checks++; if (bus0.sel !== 4'hF)   begin errors++; $display("FAIL reset_sel: got %h expected f", bus0.sel); end
      checks++; if (bus0.we !== 1'b1)    begin errors++; $display("FAIL reset_we: got %b expected 1", bus0.we); end
      checks++; if (cpu_rst0 !== 1'b1)   begin errors++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst0); end
      checks++; if (done0 !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
      checks++; if (err0 !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b expected 0", err0); end

      // Abort in the middle of a write that is never acked.
      ack_en0 = 1'b0;
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_word(32'h1234_5678);
      n = 0;
      while (n < 100 && bus0.stb !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin errors++; $display("FAIL abort_stb_seen: got stb=%b expected 1", bus0.stb); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (bus0.stb !== 1'b0) begin errors++; $display("FAIL abort_stb_async: got %b expected 0", bus0.stb); end
      checks++; if (cpu_rst0 !== 1'b1) begin errors++; $display("FAIL abort_cpu_rst: got %b expected 1", cpu_rst0); end
      checks++; if (bus0.adr !== 32'h0) begin errors++; $display("FAIL abort_adr: got %h expected 0", bus0.adr); end
      @(negedge clk);
      rst = 1'b0;
      ack_en0 = 1'b1;
   endtask

   task automatic test_image();
      wr_t o;
      wr_t e;
      do_reset();
      exp_q0.push_back('{adr: 32'h0, dat: 32'h1234_5678});
      exp_q0.push_back('{adr: 32'h4, dat: 32'hDEAD_BEEF});
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_word(32'h1234_5678);
      send_word(32'hDEAD_BEEF);
      send_trailer();
      wait_end("image", 1'b0, 400);
      repeat (2) @(negedge clk);
      checks++; if (done0 !== 1'b1)    begin errors++; $display("FAIL image_done: got %b expected 1", done0); end
      checks++; if (cpu_rst0 !== 1'b0) begin errors++; $display("FAIL image_cpu_rst: got %b expected 0", cpu_rst0); end
      checks++; if (err0 !== 1'b0)     begin errors++; $display("FAIL image_err: got %b expected 0", err0); end
      checks++;
      if (done_cyc0 !== last_ack_cyc0 + 1) begin
         errors++;
         $display("FAIL image_done_timing: done at cycle %0d expected %0d", done_cyc0, last_ack_cyc0 + 1);
      end
      checks++;
      if (obs_q0.size() !== exp_q0.size()) begin
         errors++;
         $display("FAIL image_write_count: got %0d expected %0d", obs_q0.size(), exp_q0.size());
      end
      for (int k = 0; k < obs_q0.size() && exp_q0.size() > 0; k++) begin
         e = exp_q0.pop_front();
         o = obs_q0[k];
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL image_write%0d: got adr=%h dat=%h expected adr=%h dat=%h", k, o.adr, o.dat, e.adr, e.dat);
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_trailer();
      wait_end("glitch", 1'b0, 400);
      repeat (2) @(negedge clk);
      checks++; if (done0 !== 1'b1)  begin errors++; $display("FAIL glitch_done: got %b expected 1", done0); end
      checks++; if (err0 !== 1'b0)   begin errors++; $display("FAIL glitch_err: got %b expected 0", err0); end
      checks++; if (stb_cnt0 !== 0)  begin errors++; $display("FAIL glitch_no_write: got %0d strobes expected 0", stb_cnt0); end
   endtask

   task automatic test_framing();
      do_reset();
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b0);
      wait_end("framing", 1'b0, 400);
      repeat (4) @(negedge clk);
      checks++; if (err0 !== 1'b1)     begin errors++; $display("FAIL framing_err: got %b expected 1", err0); end
      checks++; if (cpu_rst0 !== 1'b1) begin errors++; $display("FAIL framing_cpu_rst: got %b expected 1", cpu_rst0); end
      checks++; if (done0 !== 1'b0)    begin errors++; $display("FAIL framing_done: got %b expected 0", done0); end
      checks++; if (stb_cnt0 !== 0)    begin errors++; $display("FAIL framing_no_write: got %0d strobes expected 0", stb_cnt0); end
   endtask

   task automatic test_overrun();
      wr_t e;
      do_reset();
      ack_en0 = 1'b0;
      exp_q0.push_back('{adr: 32'h0, dat: 32'hA1A2_A3A4});
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_word(32'hA1A2_A3A4);
      send_word(32'hB1B2_B3B4);
      wait_end("overrun", 1'b0, 400);
      repeat (2) @(negedge clk);
      checks++; if (err0 !== 1'b1)     begin errors++; $display("FAIL overrun_err: got %b expected 1", err0); end
      checks++; if (bus0.stb !== 1'b1) begin errors++; $display("FAIL overrun_pending: got stb=%b expected 1", bus0.stb); end
      ack_en0 = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (bus0.stb !== 1'b0) begin errors++; $display("FAIL overrun_stb_drop: got %b expected 0", bus0.stb); end
      checks++; if (stb_cnt0 !== 1)    begin errors++; $display("FAIL overrun_one_stb: got %0d strobes expected 1", stb_cnt0); end
      checks++; if (done0 !== 1'b0 || cpu_rst0 !== 1'b1) begin
         errors++; $display("FAIL overrun_hold: got done=%b cpu_rst=%b expected 0/1", done0, cpu_rst0);
      end
      e = exp_q0.pop_front();
      checks++;
      if (obs_q0.size() !== 1 || obs_q0[0] !== e) begin
         errors++;
         $display("FAIL overrun_write: got %0d writes, first dat=%h expected 1 write dat=%h",
                  obs_q0.size(), (obs_q0.size() > 0) ? obs_q0[0].dat : 32'h0, e.dat);
      end
   endtask

`ifdef SERVANT_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      wr_t e;
      for (int t = 0; t < 2; t++) begin
         do_reset();
         exp_q0.push_back('{adr: 32'h0, dat: 32'h0804_0201});
         send_byte(8'h01, 1'b1);
         send_byte(8'h00, 1'b1);
         send_word(32'h0804_0201);
         send_byte((t == 0) ? 8'h0F : 8'h0E, 1'b1);
         wait_end("checksum", 1'b0, 400);
         repeat (4) @(negedge clk);
         checks++;
         if (done0 !== (t == 0) || err0 !== (t != 0)) begin
            errors++;
            $display("FAIL checksum_result%0d: got done=%b err=%b expected done=%0d err=%0d",
                     t, done0, err0, (t == 0), (t != 0));
         end
         e = exp_q0.pop_front();
         checks++;
         if (obs_q0.size() !== 1 || obs_q0[0] !== e) begin
            errors++;
            $display("FAIL checksum_write%0d: got %0d writes expected 1 with dat=%h", t, obs_q0.size(), e.dat);
         end
      end
   endtask
`endif

   task automatic test_wrap();
      wr_t o;
      wr_t e;
      logic [31:0] w;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         w = 32'hC0DE_0000 | 32'(k);
         exp_q1.push_back('{adr: 32'((k % 4) * 4), dat: w});
      end
      send_byte(8'h05, 1'b1);
      send_byte(8'h00, 1'b1);
      for (int k = 0; k < 5; k++) begin
         w = 32'hC0DE_0000 | 32'(k);
         send_word(w);
      end
      send_trailer();
      wait_end("wrap", 1'b1, 400);
      repeat (2) @(negedge clk);
      checks++; if (done1 !== 1'b1 || err1 !== 1'b0) begin
         errors++; $display("FAIL wrap_done: got done=%b err=%b expected 1/0", done1, err1);
      end
      checks++;
      if (obs_q1.size() !== exp_q1.size()) begin
         errors++;
         $display("FAIL wrap_write_count: got %0d expected %0d", obs_q1.size(), exp_q1.size());
      end
      for (int k = 0; k < obs_q1.size() && exp_q1.size() > 0; k++) begin
         e = exp_q1.pop_front();
         o = obs_q1[k];
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL wrap_write%0d: got adr=%h dat=%h expected adr=%h dat=%h", k, o.adr, o.dat, e.adr, e.dat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_image();
      test_glitch();
      test_framing();
      test_overrun();
`ifdef SERVANT_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
